// File: rtl/secuenciador_trama_if.sv
// Byte/strobe bus between the UART receiver, the frame sequencer and the capture registers.
interface secuenciador_trama_if;
    logic [7:0] dato;
    logic       tick;
    logic [7:0] dato_out;
    logic [3:0] reg_en;
    logic       commit;
    logic       active;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;

    // Receiver/testbench side: supplies bytes, observes the sequencer.
    modport master (
        output dato, tick,
        input  dato_out, reg_en, commit, active, error, err_code, frame_cnt
    );

    // Sequencer side.
    modport slave (
        input  dato, tick,
        output dato_out, reg_en, commit, active, error, err_code, frame_cnt
    );
endinterface

// File: rtl/secuenciador_trama.sv
// Frame sequencer: parses '#', decenas, unidades, presencia, ignicion, CR from the UART byte
// stream, strobes the capture registers, commits complete frames and reports errors/timeouts.
module secuenciador_trama #(
    parameter logic [7:0]  START_CHAR  = 8'h23,
    parameter logic [7:0]  END_CHAR    = 8'h0D,
    parameter int unsigned TIMEOUT_CYC = 5000000,
    parameter int unsigned CNT_W       = 23
) (
    input logic                 clk,
    input logic                 rst,
    secuenciador_trama_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWDec,
        StWUni,
        StWPre,
        StWIgn,
        StWEnd
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [7:0]       r_dato_out;
    logic [3:0]       r_reg_en;
    logic             r_commit;
    logic             r_active;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic [7:0]       r_frame_cnt;

    logic             w_is_digit;
    logic             w_is_bit;
    logic             w_byte_ok;
    logic [3:0]       w_slot;
    state_e           w_state_adv;
    logic             w_timeout;

    // Per-slot byte validation, capture strobe and successor state for the current slot.
    always_comb begin
        w_is_digit  = (bus.dato >= 8'h30) && (bus.dato <= 8'h39);
        w_is_bit    = (bus.dato == 8'h30) || (bus.dato == 8'h31);
        w_byte_ok   = 1'b0;
        w_slot      = 4'b0000;
        w_state_adv = StIdle;
        unique case (r_state)
            StWDec: begin
                w_byte_ok   = w_is_digit;
                w_slot      = 4'b0001;
                w_state_adv = StWUni;
            end
            StWUni: begin
                w_byte_ok   = w_is_digit;
                w_slot      = 4'b0010;
                w_state_adv = StWPre;
            end
            StWPre: begin
                w_byte_ok   = w_is_bit;
                w_slot      = 4'b0100;
                w_state_adv = StWIgn;
            end
            StWIgn: begin
                w_byte_ok   = w_is_bit;
                w_slot      = 4'b1000;
                w_state_adv = StWEnd;
            end
            StWEnd: begin
                w_byte_ok   = (bus.dato == END_CHAR);
                w_state_adv = StIdle;
            end
            default: begin
                w_byte_ok   = 1'b0;
            end
        endcase
        // A tick in the expiry cycle wins over the timeout.
        w_timeout = (r_state != StIdle) && !bus.tick && (r_timer == TIMEOUT_LAST);
    end

    // Frame FSM with registered strobes, error reporting and inter-byte timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_timer     <= '0;
            r_dato_out  <= 8'h00;
            r_reg_en    <= 4'b0000;
            r_commit    <= 1'b0;
            r_active    <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'd0;
            r_frame_cnt <= 8'h00;
        end else begin
            r_reg_en <= 4'b0000;
            r_commit <= 1'b0;
            r_error  <= 1'b0;
            if (bus.tick) begin
                r_timer <= '0;
                if (r_state == StIdle) begin
                    // Anything but the start char is line noise between frames.
                    if (bus.dato == START_CHAR) begin
                        r_state  <= StWDec;
                        r_active <= 1'b1;
                    end
                end else if (bus.dato == START_CHAR) begin
                    // Resync: restart the frame; stale captures get overwritten before commit.
                    r_state    <= StWDec;
                    r_active   <= 1'b1;
                    r_error    <= 1'b1;
                    r_err_code <= 2'd3;
                end else if (w_byte_ok) begin
                    if (r_state == StWEnd) begin
                        r_state     <= StIdle;
                        r_active    <= 1'b0;
                        r_commit    <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else begin
                        r_state    <= w_state_adv;
                        r_reg_en   <= w_slot;
                        r_dato_out <= bus.dato;
                    end
                end else begin
                    r_state    <= StIdle;
                    r_active   <= 1'b0;
                    r_error    <= 1'b1;
                    r_err_code <= 2'd1;
                end
            end else if (r_state != StIdle) begin
                if (w_timeout) begin
                    r_state    <= StIdle;
                    r_active   <= 1'b0;
                    r_error    <= 1'b1;
                    r_err_code <= 2'd2;
                    r_timer    <= '0;
                end else begin
                    r_timer <= r_timer + CNT_W'(1);
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign bus.dato_out  = r_dato_out;
    assign bus.reg_en    = r_reg_en;
    assign bus.commit    = r_commit;
    assign bus.active    = r_active;
    assign bus.error     = r_error;
    assign bus.err_code  = r_err_code;
    assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_secuenciador_trama.sv
// Scoreboard bench for secuenciador_trama: a frame-position model predicts every strobe,
// commit and error (with its cycle); a monitor checks whatever the DUT emits against it.
module tb_secuenciador_trama;

    localparam int         TO = 100;
    localparam logic [7:0] SC = 8'h23;
    localparam logic [7:0] EC = 8'h0D;

    typedef struct {
        int         cyc;
        logic [3:0] reg_en;
        logic       commit;
        logic       error;
        logic [7:0] dato_out;
        logic [1:0] err_code;
        logic [7:0] frame_cnt;
        logic       active;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Model: number of frame bytes accepted so far (0 = between frames).
    int         m_pos = 0;
    logic [7:0] m_fcnt = 8'h00;
    logic [1:0] m_code = 2'd0;
    ev_t        q[$];

    secuenciador_trama_if u_if ();

    secuenciador_trama #(
        .START_CHAR (SC),
        .END_CHAR   (EC),
        .TIMEOUT_CYC(TO),
        .CNT_W      (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit byte_ok(int pos, logic [7:0] b);
        if (pos == 1 || pos == 2) return (b >= 8'h30 && b <= 8'h39);
        if (pos == 3 || pos == 4) return (b == 8'h30 || b == 8'h31);
        return (b == EC);
    endfunction

    function automatic void push(int c, logic [3:0] re, logic cm, logic er, logic [7:0] d,
                                 logic act);
        ev_t e;
        e.cyc = c; e.reg_en = re; e.commit = cm; e.error = er; e.dato_out = d;
        e.err_code = m_code; e.frame_cnt = m_fcnt; e.active = act;
        q.push_back(e);
    endfunction

    function automatic void model_byte(logic [7:0] b, int t);
        if (m_pos == 0) begin
            if (b == SC) m_pos = 1;
        end else if (b == SC) begin
            m_code = 2'd3;
            m_pos  = 1;
            push(t + 1, 4'b0000, 1'b0, 1'b1, 8'h00, 1'b1);
        end else if (byte_ok(m_pos, b)) begin
            if (m_pos == 5) begin
                m_fcnt = m_fcnt + 8'd1;
                m_pos  = 0;
                push(t + 1, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0);
            end else begin
                push(t + 1, 4'(1 << (m_pos - 1)), 1'b0, 1'b0, b, 1'b1);
                m_pos = m_pos + 1;
            end
        end else begin
            m_code = 2'd1;
            m_pos  = 0;
            push(t + 1, 4'b0000, 1'b0, 1'b1, 8'h00, 1'b0);
        end
    endfunction

    // One byte, then `gap` tick-free cycles. Called at #1 after a rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        u_if.dato = b;
        u_if.tick = 1'b1;
        t = cyc;
        model_byte(b, t);
        // TO quiet cycles in a row mid-frame expire the frame.
        if (m_pos != 0 && gap >= TO) begin
            m_code = 2'd2;
            m_pos  = 0;
            push(t + TO + 1, 4'b0000, 1'b0, 1'b1, 8'h00, 1'b0);
        end
        @(posedge clk); #1;
        u_if.tick = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int d, input int u, input int p, input int i, input int gap);
        send(SC, gap);
        send(8'(8'h30 + d), gap);
        send(8'(8'h30 + u), gap);
        send(8'(8'h30 + p), gap);
        send(8'(8'h30 + i), gap);
        send(EC, gap);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (u_if.dato_out != 0 || u_if.reg_en != 0 || u_if.commit || u_if.active ||
            u_if.error || u_if.err_code != 0 || u_if.frame_cnt != 0) begin
            n_fail++;
            $display("FAIL %s: dato_out=%h reg_en=%b commit=%b active=%b error=%b code=%0d cnt=%0d, required all 0",
                     name, u_if.dato_out, u_if.reg_en, u_if.commit, u_if.active, u_if.error,
                     u_if.err_code, u_if.frame_cnt);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * TO && q.size() != 0; i++) @(posedge clk);
        #1;
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 80) return $urandom_range(0, 3);
        if (r < 88) return TO - 1;
        if (r < 94) return TO;
        return $urandom_range(4, 20);
    endfunction

    // Monitor: every DUT strobe/commit/error must match the next predicted event.
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_event: nothing at cycle %0d, required reg_en=%b commit=%b error=%b",
                         q[0].cyc, q[0].reg_en, q[0].commit, q[0].error);
                void'(q.pop_front());
            end
            if (u_if.reg_en != 0 || u_if.commit || u_if.error) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d reg_en=%b commit=%b error=%b, required none",
                             cyc, u_if.reg_en, u_if.commit, u_if.error);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || u_if.reg_en != e.reg_en || u_if.commit != e.commit ||
                        u_if.error != e.error || u_if.err_code != e.err_code ||
                        u_if.frame_cnt != e.frame_cnt || u_if.active != e.active ||
                        (e.reg_en != 0 && u_if.dato_out != e.dato_out)) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d re=%b cm=%b er=%b code=%0d cnt=%0d act=%b d=%h; required cyc=%0d re=%b cm=%b er=%b code=%0d cnt=%0d act=%b d=%h",
                                 cyc, u_if.reg_en, u_if.commit, u_if.error, u_if.err_code,
                                 u_if.frame_cnt, u_if.active, u_if.dato_out, e.cyc, e.reg_en,
                                 e.commit, e.error, e.err_code, e.frame_cnt, e.active,
                                 e.dato_out);
                    end
                end
            end
        end
    end

    initial begin
        u_if.dato = 8'h00;
        u_if.tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("after_release");

        // Reference frame with wide spacing.
        send_frame(2, 7, 1, 0, 19);
        // Bad decenas/unidades char, then a clean frame.
        send(SC, 3); send(8'h32, 3); send(8'h41, 3);
        send_frame(9, 0, 0, 1, 2);
        // Resync in the middle of a frame.
        send(SC, 1); send(8'h33, 1); send_frame(1, 5, 0, 1, 1);
        // Timeout exactly at the limit, then a tick landing in the last allowed cycle.
        send(SC, 2); send(8'h34, TO);
        send(SC, 2); send(8'h34, TO - 1); send(8'h35, 2);
        send(8'h31, 0); send(8'h30, 0); send(EC, 2);
        // Bad presencia, then idle garbage.
        send(SC, 0); send(8'h31, 0); send(8'h32, 0); send(8'h32, 2);
        send(8'h78, 1); send(8'h39, 1);

        // Enough frames to wrap frame_cnt.
        for (int n = 0; n < 256; n++) begin
            send_frame($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 2));
        end

        // Random mix of valid frames and noisy byte runs.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 5) begin
                send_frame($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1),
                           $urandom_range(0, 1), pick_gap());
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                    logic [7:0] pool [9];
                    pool = '{SC, EC, 8'h30, 8'h31, 8'h32, 8'h35, 8'h39, 8'h41, 8'h78};
                    send(pool[$urandom_range(0, 8)], pick_gap());
                end
            end
        end

        // Reset in the middle of W_PRE: immediate abort, no later commit.
        drain();
        send(SC, 1); send(8'h31, 1); send(8'h32, 1);
        rst = 1'b0;
        m_pos = 0; m_fcnt = 8'h00; m_code = 2'd0;
        q.delete();
        #1;
        check_zero("async_reset_mid_frame");
        @(posedge clk); #1;
        check_zero("reset_held");
        rst = 1'b1;
        @(posedge clk); #1;
        send(8'h31, 2); send(EC, 2);
        check_zero("no_commit_after_reset");

        repeat (TO + 10) @(posedge clk);
        #1;
        n_tests++;
        if (q.size() != 0 || u_if.active != (m_pos != 0)) begin
            n_fail++;
            $display("FAIL final_state: pending=%0d active=%b, required pending=0 active=%b",
                     q.size(), u_if.active, m_pos != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/secuenciador_trama.md
Name: secuenciador_trama

Overview:
Frame-level controller for the UART receive capture path. Watches each received byte (dato qualified by tick) and parses a fixed frame: start char, decenas, unidades, presencia, ignicion, end char. Issues one-hot load strobes to the four capture registers, a commit pulse on a complete valid frame, and error/timeout reporting. Sits between the UART receiver and the capture registers and decoder.

Parameters:
START_CHAR, 8'h23, ASCII '#' opening a frame
END_CHAR, 8'h0D, ASCII CR closing a frame
TIMEOUT_CYC, 5000000, max clk cycles between ticks while mid-frame (100 ms @ 50 MHz)
CNT_W, 23, timeout counter width; must hold TIMEOUT_CYC

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous, active-low reset
dato  input  8  received byte, valid only when tick=1
tick  input  1  one-cycle byte-received strobe, synchronous to clk
dato_out  output  8  registered copy of dato, valid whenever reg_en is nonzero
reg_en  output  4  one-hot load strobe: [0] decenas, [1] unidades, [2] presencia, [3] ignicion
commit  output  1  one-cycle pulse: frame complete and valid
active  output  1  high while a frame is in progress
error  output  1  one-cycle error pulse
err_code  output  2  error cause, held until the next error or reset: 1 bad char, 2 timeout, 3 resync
frame_cnt  output  8  count of committed frames, wraps 255->0

Behaviour:
- Reset (rst=0, async): state IDLE; dato_out=0, reg_en=0, commit=0, active=0, error=0, err_code=0, frame_cnt=0, timer=0.
- States: IDLE, W_DEC, W_UNI, W_PRE, W_IGN, W_END. Transitions occur only on cycles with tick=1, except timeout.
- IDLE: tick with dato==START_CHAR -> W_DEC. Any other byte is ignored silently, with no error.
- W_DEC / W_UNI: byte must be '0'..'9' (8'h30..8'h39).
- W_PRE / W_IGN: byte must be '0' or '1'.
- A valid data byte advances to the next state. reg_en bit for that slot is high for exactly 1 cycle, the cycle after the tick. dato_out is loaded in the same edge, so latency from tick to strobe is 1 clk.
- W_END: dato==END_CHAR -> IDLE. commit=1 for 1 cycle, the cycle after the tick, and frame_cnt increments in that same edge.
- Invalid byte in any non-IDLE state: -> IDLE; error=1 for 1 cycle; err_code=1; no reg_en, no commit.
- START_CHAR received in any non-IDLE state: -> W_DEC (restart); error=1; err_code=3. The resync check takes priority over the digit check. Already-loaded registers are not cleared; they are overwritten by the new frame before the next commit.
- Timeout: timer clears to 0 on every tick and in IDLE, and increments each clk in non-IDLE states. When timer==TIMEOUT_CYC-1 with no tick in that cycle: -> IDLE; error=1; err_code=2.
- Tick and timeout in the same cycle: the tick wins; the byte is processed normally and the timer clears.
- active=1 in every state except IDLE; it is registered from the next-state value.
- Outputs reg_en, commit and error are mutually exclusive in any cycle. Back-to-back ticks on consecutive cycles are supported.
- err_code changes only when error pulses.
- Reset asserted mid-frame aborts immediately to the reset values above, with no commit and no error pulse.

Test Plan:
- Frame '#','2','7','1','0',CR, ticks 20 cycles apart -> reg_en 0001, 0010, 0100, 1000, each 1 cycle after its tick, with dato_out 8'h32, 8'h37, 8'h31, 8'h30; commit 1 cycle after the CR tick; frame_cnt=1; active high from after '#' until commit.
- '#','2','A' -> error pulse after 'A', err_code=1, state IDLE, only reg_en[0] strobed, no commit; a following full valid frame commits normally.
- '#','3','#','1','5','0','1',CR -> error with err_code=3 on the second '#'; the frame then completes with reg_en sequence 0001..1000 and commit; frame_cnt increments once.
- TIMEOUT_CYC=100; '#','4' then silence -> error exactly 100 cycles after the '4' tick, err_code=2, active=0. Repeat with a tick landing on cycle 99: no timeout, byte processed.
- Presencia byte '2' -> err_code=1. Garbage bytes 'x','9' while IDLE -> no error, no strobes.
- 256 valid frames -> frame_cnt wraps to 0. Drop rst low during W_PRE -> all outputs 0 asynchronously; no commit after release.
